bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Arbiter for the shared serial data bus. It grants bus ownership to one of several masters, using round-robin or fixed priority. It drives the bus-utilisation flag that slaves monitor to detect the end of a peer transaction. A watchdog forcibly reclaims the bus from a master that holds it too long. The arbiter sits beside the bus, one instance per bus, between the master request lines and the shared `bus_util` net.

## Interface
- `NUM_MASTERS`, default 4: number of requesting masters, 2..8.
- `TIMEOUT_CYCLES`, default 256: maximum consecutive grant cycles per transaction, ≥2.
- `ID_WIDTH`, default `$clog2(NUM_MASTERS)`: width of master index, minimum 1.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `m_req`, input, NUM_MASTERS: per-master request, held high for the whole transaction.
- `arb_mode`, input, 1: 0 = round-robin, 1 = fixed priority (lowest index wins). Sampled only in IDLE.
- `m_grant`, output, NUM_MASTERS: one-hot grant, registered.
- `bus_util`, output, 1: high while any grant is active, registered.
- `owner_id`, output, ID_WIDTH: index of current or last owner.
- `timeout_pulse`, output, 1: one-cycle pulse when the watchdog revokes a grant.
- `timeout_id`, output, ID_WIDTH: index of the master last revoked by the watchdog.

## Operation
- States: IDLE, BUSY, TURNAROUND.
- IDLE:
  - The eligible set is `m_req & ~mask`.
  - If the set is non-empty, the winner is chosen by `arb_mode`:
    - Round-robin: first eligible index searching upward, wrapping, starting at `ptr`.
    - Fixed: lowest eligible index.
  - On a winner: `m_grant <= onehot(winner)`, `bus_util <= 1`, `owner_id <= winner`, `ptr <= winner+1` (wraps mod NUM_MASTERS; updated in both modes), `cnt <= 0`, go to BUSY.
- BUSY:
  - If `m_req[owner_id]` is low: clear `m_grant` and `bus_util`, go to TURNAROUND.
  - Else if `cnt == TIMEOUT_CYCLES-1`:
    - Clear `m_grant` and `bus_util`.
    - `timeout_pulse <= 1`, `timeout_id <= owner_id`.
    - `mask[owner_id] <= 1`.
    - Go to TURNAROUND.
  - Else `cnt <= cnt+1`.
- TURNAROUND: one idle bus cycle, then go to IDLE. No grant is issued in this state.
- Mask:
  - A set `mask[i]` clears on any edge where `m_req[i]` is sampled low.
  - A masked master cannot win, so a timed-out master must drop and re-raise its request.
- Simultaneous events:
  - Release and timeout on the same edge: release wins, no pulse.
  - Request drop in the IDLE arbitration cycle: not granted.
- `cnt` width is `$clog2(TIMEOUT_CYCLES)`. It never wraps because the timeout fires first.
- Reset clears all state: `m_grant=0`, `bus_util=0`, `owner_id=0`, `timeout_pulse=0`, `timeout_id=0`, `mask=0`, `ptr=0`, `cnt=0`, state IDLE.
- Reset mid-BUSY drops the grant immediately (asynchronously).

## Timing
- Grant latency: request sampled high at edge n in IDLE → `m_grant`/`bus_util` high after edge n.
- Release: request low sampled at edge m → grant low after m. TURNAROUND occupies cycle m..m+1. The earliest next grant is after edge m+2.
- Timeout: with the grant raised at edge n and the request held, the grant drops after edge n+TIMEOUT_CYCLES. The grant is therefore held exactly TIMEOUT_CYCLES cycles.
- `timeout_pulse` is high for exactly the cycle after the revoking edge.
- `arb_mode` changes during BUSY take effect at the next IDLE arbitration.

## Structure
- A shared package `bus_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, BUSY=2'd1, TURNAROUND=2'd2);
  - the ID width helper function, which is common with the master and slave modules.
- One combinational sub-module, `rr_picker`. Inputs: `req` vector, start `ptr`, mode. Outputs: winner index and `valid`. It keeps the FSM free of the search loop and is reusable by future bus instances.

## Test plan
Bench parameters: NUM_MASTERS=4, TIMEOUT_CYCLES=8.
1. Reset, then `m_req=4'b0100` for 3 cycles, then 0 → `m_grant=4'b0100` one cycle after the request, `owner_id=2`, `bus_util` high for 3 cycles, one TURNAROUND cycle, back to IDLE.
2. Round-robin with `m_req=4'b1111` held, each master dropping its request after 2 grant cycles and re-raising it → grant order 0,1,2,3,0 with one idle cycle between grants.
3. Fixed priority, `arb_mode=1`, `m_req=4'b1010` with master 1 re-requesting immediately after each release → master 1 wins every arbitration and master 3 is starved.
4. Master 0 holds its request for 20 cycles → grant held exactly 8 cycles, `timeout_pulse` for 1 cycle, `timeout_id=0`. Master 0 is not re-granted while its request stays high. After the request drops and rises again it is granted.
5. On the edge where `cnt=7`, master 2 drops its request → normal release, no `timeout_pulse`.
6. Assert `rstn` low mid-BUSY with `m_grant=4'b0010` → `m_grant`, `bus_util` and `timeout_pulse` go to 0 asynchronously. After reset release with `m_req=4'b0011`, master 0 wins because `ptr` is back at 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial data bus: arbiter state encoding and master-index width.
package bus_pkg;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BUSY       = 2'd1;
  localparam logic [1:0] TURNAROUND = 2'd2;

  typedef enum logic [1:0] {
    StIdle       = IDLE,
    StBusy       = BUSY,
    StTurnaround = TURNAROUND
  } arb_state_e;

  // Width of a master index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner search: rotating from ptr_i (round-robin) or from index 0 (fixed).
module rr_picker
  import bus_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = id_width(NumReq)
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  input  logic               mode_i,
  output logic [IdWidth-1:0] winner_o,
  output logic               valid_o
);

  // First requester found walking upward from the start index, wrapping at NumReq.
  always_comb begin : pick
    logic [IdWidth-1:0] idx;
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = mode_i ? IdWidth'(k) : IdWidth'((32'(ptr_i) + k) % NumReq);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin / fixed-priority grant, bus_util flag and grant watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ID_WIDTH       = id_width(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic                   arb_mode,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic                   bus_util,
  output logic [ID_WIDTH-1:0]    owner_id,
  output logic                   timeout_pulse,
  output logic [ID_WIDTH-1:0]    timeout_id
);

  localparam int unsigned         CntWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(TIMEOUT_CYCLES - 1);

  arb_state_e               state_q;
  logic [NUM_MASTERS-1:0]   grant_q;
  logic                     util_q;
  logic [ID_WIDTH-1:0]      owner_q;
  logic                     pulse_q;
  logic [ID_WIDTH-1:0]      tid_q;
  logic [NUM_MASTERS-1:0]   mask_q, mask_d;
  logic [ID_WIDTH-1:0]      ptr_q;
  logic [CntWidth-1:0]      cnt_q;

  logic [ID_WIDTH-1:0]      pick_id;
  logic                     pick_valid;
  logic [ID_WIDTH-1:0]      ptr_next;
  logic                     owner_req;
  logic                     timeout_hit;

  rr_picker #(
    .NumReq  (NUM_MASTERS),
    .IdWidth (ID_WIDTH)
  ) u_picker (
    .req_i    (m_req & ~mask_q),
    .ptr_i    (ptr_q),
    .mode_i   (arb_mode),
    .winner_o (pick_id),
    .valid_o  (pick_valid)
  );

  // Owner status and the pointer position just past the current winner.
  always_comb begin
    owner_req   = m_req[owner_q];
    timeout_hit = (state_q == StBusy) && owner_req && (cnt_q == CntMax);
    ptr_next    = (pick_id == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : pick_id + 1'b1;
  end

  // Mask drops with the request; a revoked owner stays masked until it lets go.
  always_comb begin
    mask_d = mask_q & m_req;
    if (timeout_hit) begin
      mask_d[owner_q] = 1'b1;
    end
  end

  // Arbitration FSM with registered outputs; reset drops the grant asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      grant_q <= '0;
      util_q  <= 1'b0;
      owner_q <= '0;
      pulse_q <= 1'b0;
      tid_q   <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      mask_q  <= mask_d;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q <= NUM_MASTERS'(1) << pick_id;
            util_q  <= 1'b1;
            owner_q <= pick_id;
            ptr_q   <= ptr_next;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // Release takes precedence over a timeout on the same edge.
          if (!owner_req) begin
            grant_q <= '0;
            util_q  <= 1'b0;
            state_q <= StTurnaround;
          end else if (cnt_q == CntMax) begin
            grant_q <= '0;
            util_q  <= 1'b0;
            pulse_q <= 1'b1;
            tid_q   <= owner_q;
            state_q <= StTurnaround;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StTurnaround: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_grant       = grant_q;
  assign bus_util      = util_q;
  assign owner_id      = owner_q;
  assign timeout_pulse = pulse_q;
  assign timeout_id    = tid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random requests against a transaction-level model.
module tb_bus_arbiter;

  localparam int N   = 4;
  localparam int T   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   m_req = '0;
  logic           arb_mode = 1'b0;
  logic [N-1:0]   m_grant;
  logic           bus_util;
  logic [IDW-1:0] owner_id;
  logic           timeout_pulse;
  logic [IDW-1:0] timeout_id;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how long, and who is locked out.
  bit       md_granted;
  int       md_owner;
  int       md_hold;
  bit       md_gap;
  bit [N-1:0] md_mask;
  int       md_ptr;
  bit       md_pulse;
  int       md_tid;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .m_req         (m_req),
    .arb_mode      (arb_mode),
    .m_grant       (m_grant),
    .bus_util      (bus_util),
    .owner_id      (owner_id),
    .timeout_pulse (timeout_pulse),
    .timeout_id    (timeout_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_granted = 0; md_owner = 0; md_hold = 0; md_gap = 0;
    md_mask = '0; md_ptr = 0; md_pulse = 0; md_tid = 0;
  endtask

  // One clock edge of the bus rules, given the sampled requests and mode.
  task automatic model_edge(input logic [N-1:0] r, input logic md);
    bit found;
    bit revoked;
    int w;
    md_pulse = 0;
    revoked  = 0;
    found    = 0;
    w        = 0;
    if (md_granted) begin
      md_hold++;
      if (!r[md_owner]) begin
        md_granted = 0;
        md_gap     = 1;
      end else if (md_hold == T) begin
        md_granted = 0;
        md_gap     = 1;
        md_pulse   = 1;
        md_tid     = md_owner;
        revoked    = 1;
      end
    end else if (md_gap) begin
      md_gap = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = md ? k : (md_ptr + k) % N;
        if (!found && r[idx] && !md_mask[idx]) begin
          found = 1;
          w     = idx;
        end
      end
      if (found) begin
        md_granted = 1;
        md_owner   = w;
        md_ptr     = (w + 1) % N;
        md_hold    = 0;
      end
    end
    for (int i = 0; i < N; i++) if (!r[i]) md_mask[i] = 0;
    if (revoked) md_mask[md_owner] = 1;
  endtask

  task automatic compare_all();
    check("grant", 32'(m_grant), md_granted ? (32'd1 << md_owner) : 32'd0);
    check("util", 32'(bus_util), 32'(md_granted));
    check("owner", 32'(owner_id), 32'(md_owner));
    check("pulse", 32'(timeout_pulse), 32'(md_pulse));
    check("tid", 32'(timeout_id), 32'(md_tid));
  endtask

  // Drive inputs, clock once, advance the model, compare away from the edge.
  task automatic step(input logic [N-1:0] r, input logic md);
    m_req    = r;
    arb_mode = md;
    @(posedge clk);
    model_edge(r, md);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn  = 1'b0;
    m_req = '0;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic         md;
    int           seen;
    int           order[5];
    bit           prev_util;
    int           gcycles;
    int           pulses;

    order = '{0, 1, 2, 3, 0};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(m_grant), 32'd0);
    check("rst_util", 32'(bus_util), 32'd0);
    check("rst_owner", 32'(owner_id), 32'd0);
    check("rst_pulse", 32'(timeout_pulse), 32'd0);
    check("rst_tid", 32'(timeout_id), 32'd0);
    rstn = 1'b1;

    // Single master, three grant cycles, then release and turnaround.
    step(4'b0100, 1'b0);
    check("t1_grant", 32'(m_grant), 32'h4);
    check("t1_owner", 32'(owner_id), 32'd2);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    check("t1_util_low", 32'(bus_util), 32'd0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Round-robin rotation with everyone requesting.
    do_reset();
    seen = 0;
    prev_util = 1'b0;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      r = 4'b1111;
      if (md_granted && md_hold == 1) r[md_owner] = 1'b0;
      step(r, 1'b0);
      if (bus_util && !prev_util) begin
        check("t2_order", 32'(owner_id), 32'(order[seen]));
        seen++;
      end
      prev_util = bus_util;
    end
    check("t2_grants", 32'(seen), 32'd5);

    // Fixed priority starves master 3.
    repeat (3) step(4'b0000, 1'b0);
    prev_util = 1'b0;
    for (int c = 0; c < 30; c++) begin
      r = 4'b1010;
      if (md_granted && md_hold == 1) r[1] = 1'b0;
      step(r, 1'b1);
      check("t3_no_m3", 32'(m_grant[3]), 32'd0);
      if (bus_util && !prev_util) check("t3_owner", 32'(owner_id), 32'd1);
      prev_util = bus_util;
    end

    // Watchdog revokes master 0 after exactly T cycles and locks it out.
    repeat (3) step(4'b0000, 1'b0);
    gcycles = 0;
    pulses  = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0001, 1'b0);
      if (bus_util) gcycles++;
      if (timeout_pulse) pulses++;
    end
    check("t4_held", 32'(gcycles), 32'(T));
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_tid", 32'(timeout_id), 32'd0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    check("t4_regrant", 32'(m_grant), 32'h1);

    // Release on the last allowed cycle wins over the timeout.
    repeat (3) step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    check("t5_grant", 32'(m_grant), 32'h4);
    repeat (7) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    check("t5_no_pulse", 32'(timeout_pulse), 32'd0);
    check("t5_released", 32'(m_grant), 32'd0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    check("t6_pre", 32'(m_grant), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_async_grant", 32'(m_grant), 32'd0);
    check("t6_async_util", 32'(bus_util), 32'd0);
    check("t6_async_pulse", 32'(timeout_pulse), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(4'b0011, 1'b0);
    check("t6_owner", 32'(owner_id), 32'd0);
    check("t6_grant", 32'(m_grant), 32'h1);

    // Random request traffic and mode changes.
    r  = '0;
    md = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      if ($urandom_range(0, 19) == 0) md = ~md;
      step(r, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
